// File: rtl/pipe_ctrl.sv
// Central stall/flush controller for a five-register in-order pipeline.
// Arbitrates fetch/decode stall requests, EX branch redirects and multi-cycle
// memory accesses into per-register hold/flush strobes and a PC redirect.
// A memory access that outlasts MEM_TIMEOUT cycles parks the pipeline in a
// sticky error state that only reset can leave.
module pipe_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_stallreq,
  input  logic             id_stallreq,
  input  logic             ex_branch_taken,
  input  logic [31:0]      ex_branch_pc,
  input  logic             mem_req,
  input  logic             mem_done,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             if_id_flush,
  output logic             id_ex_hold,
  output logic             id_ex_flush,
  output logic             ex_mem_hold,
  output logic             mem_wb_flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  // One extra bit so the incremented wait count can never alias to zero.
  localparam logic [WAIT_W:0]   WAIT_LIMIT = (WAIT_W + 1)'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_FIRST = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [WAIT_W:0]   wait_inc;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  assign wait_inc = {1'b0, wait_cnt_q} + 1'b1;

  // Next-state logic and the combinational hold/flush/redirect strobes.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case/if tree can leave one unassigned and infer a latch.
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    err_d          = err_q;
    pc_hold        = 1'b0;
    if_id_hold     = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_hold     = 1'b0;
    id_ex_flush    = 1'b0;
    ex_mem_hold    = 1'b0;
    mem_wb_flush   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    if (!rst) begin
      // Fill every stage with bubbles while reset is held.
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (mem_req && !mem_done) begin
            pc_hold      = 1'b1;
            if_id_hold   = 1'b1;
            id_ex_hold   = 1'b1;
            ex_mem_hold  = 1'b1;
            mem_wb_flush = 1'b1;
            state_d      = ST_MEM_WAIT;
            wait_cnt_d   = WAIT_FIRST;
          end else if (ex_branch_taken) begin
            redirect_valid = 1'b1;
            redirect_pc    = ex_branch_pc;
            if_id_flush    = 1'b1;
            id_ex_flush    = 1'b1;
          end else if (id_stallreq) begin
            pc_hold     = 1'b1;
            if_id_hold  = 1'b1;
            id_ex_flush = 1'b1;
          end else if (if_stallreq) begin
            pc_hold     = 1'b1;
            if_id_flush = 1'b1;
          end
        end

        ST_MEM_WAIT: begin
          if (mem_done) begin
            // Pipeline advances on this edge; branch/stall requests wait for RUN.
            state_d = ST_RUN;
          end else begin
            pc_hold      = 1'b1;
            if_id_hold   = 1'b1;
            id_ex_hold   = 1'b1;
            ex_mem_hold  = 1'b1;
            mem_wb_flush = 1'b1;
            if (wait_inc >= WAIT_LIMIT) begin
              wait_cnt_d = WAIT_LIMIT[WAIT_W-1:0];
              state_d    = ST_ERR;
              err_d      = 1'b1;
            end else begin
              wait_cnt_d = wait_inc[WAIT_W-1:0];
            end
          end
        end

        ST_ERR: begin
          pc_hold      = 1'b1;
          if_id_hold   = 1'b1;
          id_ex_hold   = 1'b1;
          ex_mem_hold  = 1'b1;
          mem_wb_flush = 1'b1;
          err_d        = 1'b1;
        end

        default: begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end
      endcase
    end
  end

  // Saturating performance counters: stalled cycles and taken redirects.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_hold && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (redirect_valid && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // State, wait counter, error flag and perf counters with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its _d value from before the edge, independent of statement order.
    if (!rst) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign err       = err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a cycle-by-cycle vector table covering reset
// and the RUN priority order, then hand-written multi-cycle sequences for
// memory wait, branch-during-wait, counter saturation, reset mid-wait and
// memory timeout. Inputs change on the falling edge; outputs are sampled
// 1 ns later, well away from the rising edge.
module tb_pipe_ctrl;

  localparam int unsigned CNT_W = 4;

  // Output vector order:
  // {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_hold, mem_wb_flush, redirect_valid}
  localparam logic [7:0] O_ZERO = 8'b0000_0000;
  localparam logic [7:0] O_RST  = 8'b0010_1010;
  localparam logic [7:0] O_HOLD = 8'b1101_0110;
  localparam logic [7:0] O_BR   = 8'b0010_1001;
  localparam logic [7:0] O_ID   = 8'b1100_1000;
  localparam logic [7:0] O_IF   = 8'b1010_0000;

  typedef struct {
    logic             rst;
    logic             ifs;
    logic             ids;
    logic             br;
    logic [31:0]      bpc;
    logic             mreq;
    logic             mdone;
    logic [7:0]       exp_o;
    logic [31:0]      exp_pc;
    logic             chk_regs;
    logic [CNT_W-1:0] exp_stall;
    logic [CNT_W-1:0] exp_flush;
    logic             exp_err;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             if_stallreq = 1'b0;
  logic             id_stallreq = 1'b0;
  logic             ex_branch_taken = 1'b0;
  logic [31:0]      ex_branch_pc = 32'h0;
  logic             mem_req = 1'b0;
  logic             mem_done = 1'b0;
  logic             pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush;
  logic             ex_mem_hold, mem_wb_flush, redirect_valid, err;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_stallreq    (if_stallreq),
    .id_stallreq    (id_stallreq),
    .ex_branch_taken(ex_branch_taken),
    .ex_branch_pc   (ex_branch_pc),
    .mem_req        (mem_req),
    .mem_done       (mem_done),
    .pc_hold        (pc_hold),
    .if_id_hold     (if_id_hold),
    .if_id_flush    (if_id_flush),
    .id_ex_hold     (id_ex_hold),
    .id_ex_flush    (id_ex_flush),
    .ex_mem_hold    (ex_mem_hold),
    .mem_wb_flush   (mem_wb_flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .err            (err),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic ifs, input logic ids, input logic br,
                              input logic [31:0] bpc, input logic mreq, input logic mdone,
                              input logic [7:0] eo, input logic [31:0] epc, input logic cr,
                              input int es, input int ef, input logic ee);
    vec_t v;
    v.rst = r; v.ifs = ifs; v.ids = ids; v.br = br; v.bpc = bpc;
    v.mreq = mreq; v.mdone = mdone; v.exp_o = eo; v.exp_pc = epc;
    v.chk_regs = cr; v.exp_stall = CNT_W'(es); v.exp_flush = CNT_W'(ef); v.exp_err = ee;
    return v;
  endfunction

  // Drive one cycle's inputs on the falling edge and check this cycle's outputs.
  task automatic run_vec(input vec_t v, input string tag);
    logic [7:0] act_o;
    @(negedge clk);
    rst             = v.rst;
    if_stallreq     = v.ifs;
    id_stallreq     = v.ids;
    ex_branch_taken = v.br;
    ex_branch_pc    = v.bpc;
    mem_req         = v.mreq;
    mem_done        = v.mdone;
    #1;
    act_o = {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush,
             ex_mem_hold, mem_wb_flush, redirect_valid};
    check({tag, " strobes"}, {24'h0, act_o}, {24'h0, v.exp_o});
    check({tag, " redirect_pc"}, redirect_pc, v.exp_pc);
    if (v.chk_regs) begin
      check({tag, " stall_cnt"}, {28'h0, stall_cnt}, {28'h0, v.exp_stall});
      check({tag, " flush_cnt"}, {28'h0, flush_cnt}, {28'h0, v.exp_flush});
      check({tag, " err"}, {31'h0, err}, {31'h0, v.exp_err});
    end
  endtask

  vec_t tbl[13];

  initial begin
    //            rst ifs ids br  bpc       mreq mdone exp_o   exp_pc    regs stall flush err
    tbl[0]  = mk(0,  0,  0,  0,  32'h0,    0,   0,    O_RST,  32'h0,    0,   0,    0,    0);
    tbl[1]  = mk(0,  0,  0,  0,  32'h0,    0,   0,    O_RST,  32'h0,    1,   0,    0,    0);
    tbl[2]  = mk(1,  0,  0,  0,  32'h0,    0,   0,    O_ZERO, 32'h0,    1,   0,    0,    0);
    tbl[3]  = mk(1,  0,  1,  0,  32'h0,    0,   0,    O_ID,   32'h0,    1,   0,    0,    0);
    tbl[4]  = mk(1,  0,  0,  0,  32'h0,    0,   0,    O_ZERO, 32'h0,    1,   1,    0,    0);
    tbl[5]  = mk(1,  0,  1,  1,  32'h80,   0,   0,    O_BR,   32'h80,   1,   1,    0,    0);
    tbl[6]  = mk(1,  0,  0,  0,  32'h80,   0,   0,    O_ZERO, 32'h0,    1,   1,    1,    0);
    tbl[7]  = mk(1,  1,  0,  0,  32'h0,    0,   0,    O_IF,   32'h0,    1,   1,    1,    0);
    tbl[8]  = mk(1,  1,  1,  0,  32'h0,    0,   0,    O_ID,   32'h0,    1,   2,    1,    0);
    tbl[9]  = mk(1,  1,  0,  1,  32'h44,   0,   0,    O_BR,   32'h44,   1,   3,    1,    0);
    tbl[10] = mk(1,  0,  1,  0,  32'h0,    1,   1,    O_ID,   32'h0,    1,   3,    2,    0);
    tbl[11] = mk(1,  0,  0,  1,  32'h10,   1,   1,    O_BR,   32'h10,   1,   4,    2,    0);
    tbl[12] = mk(1,  0,  0,  0,  32'h0,    0,   0,    O_ZERO, 32'h0,    1,   4,    3,    0);

    for (int i = 0; i < 13; i++) begin
      run_vec(tbl[i], $sformatf("tbl%0d", i));
    end

    // Memory wait released by mem_done on cycle 3; decode stalls are ignored meanwhile.
    run_vec(mk(1, 0, 0, 0, 32'h0, 1, 0, O_HOLD, 32'h0, 1, 4, 3, 0), "memA c0");
    run_vec(mk(1, 0, 1, 0, 32'h0, 1, 0, O_HOLD, 32'h0, 1, 5, 3, 0), "memA c1");
    run_vec(mk(1, 0, 0, 0, 32'h0, 1, 0, O_HOLD, 32'h0, 1, 6, 3, 0), "memA c2");
    run_vec(mk(1, 0, 1, 0, 32'h0, 1, 1, O_ZERO, 32'h0, 1, 7, 3, 0), "memA c3");
    run_vec(mk(1, 0, 0, 0, 32'h0, 0, 0, O_ZERO, 32'h0, 1, 7, 3, 0), "memA c4");

    // Branch held during the wait is serviced only once back in RUN.
    run_vec(mk(1, 0, 0, 0, 32'h0,   1, 0, O_HOLD, 32'h0,   1, 7,  3, 0), "memB c0");
    run_vec(mk(1, 0, 0, 1, 32'h200, 1, 0, O_HOLD, 32'h0,   1, 8,  3, 0), "memB c1");
    run_vec(mk(1, 0, 0, 1, 32'h200, 1, 0, O_HOLD, 32'h0,   1, 9,  3, 0), "memB c2");
    run_vec(mk(1, 0, 0, 1, 32'h200, 1, 1, O_ZERO, 32'h0,   1, 10, 3, 0), "memB c3");
    run_vec(mk(1, 0, 0, 1, 32'h200, 0, 0, O_BR,   32'h200, 1, 10, 3, 0), "memB c4");
    run_vec(mk(1, 0, 0, 0, 32'h0,   0, 0, O_ZERO, 32'h0,   1, 10, 4, 0), "memB c5");

    // stall_cnt climbs to 15 and must stick there.
    for (int k = 0; k < 6; k++) begin
      run_vec(mk(1, 1, 0, 0, 32'h0, 0, 0, O_IF, 32'h0, 1, 10 + k, 4, 0), $sformatf("sat c%0d", k));
    end
    run_vec(mk(1, 1, 0, 0, 32'h0, 0, 0, O_IF,   32'h0, 1, 15, 4, 0), "sat c6");
    run_vec(mk(1, 0, 0, 0, 32'h0, 0, 0, O_ZERO, 32'h0, 1, 15, 4, 0), "sat c7");

    // Reset in the middle of a memory wait returns to RUN and clears counters.
    run_vec(mk(1, 0, 0, 0, 32'h0, 1, 0, O_HOLD, 32'h0, 1, 15, 4, 0), "rstw c0");
    run_vec(mk(0, 0, 0, 0, 32'h0, 1, 0, O_RST,  32'h0, 0, 0,  0, 0), "rstw c1");
    run_vec(mk(1, 0, 0, 0, 32'h0, 0, 0, O_ZERO, 32'h0, 1, 0,  0, 0), "rstw c2");

    // Timeout with MEM_TIMEOUT=4: err from cycle 4, later inputs ignored, reset clears.
    run_vec(mk(1, 0, 0, 0, 32'h0,   1, 0, O_HOLD, 32'h0, 1, 0, 0, 0), "tmo c0");
    run_vec(mk(1, 0, 0, 0, 32'h0,   1, 0, O_HOLD, 32'h0, 1, 1, 0, 0), "tmo c1");
    run_vec(mk(1, 0, 0, 0, 32'h0,   1, 0, O_HOLD, 32'h0, 1, 2, 0, 0), "tmo c2");
    run_vec(mk(1, 0, 0, 0, 32'h0,   1, 0, O_HOLD, 32'h0, 1, 3, 0, 0), "tmo c3");
    run_vec(mk(1, 0, 0, 0, 32'h0,   1, 0, O_HOLD, 32'h0, 1, 4, 0, 1), "tmo c4");
    run_vec(mk(1, 0, 0, 0, 32'h0,   1, 0, O_HOLD, 32'h0, 1, 5, 0, 1), "tmo c5");
    run_vec(mk(1, 0, 0, 0, 32'h0,   1, 1, O_HOLD, 32'h0, 1, 6, 0, 1), "tmo c6");
    run_vec(mk(1, 1, 1, 1, 32'h300, 0, 0, O_HOLD, 32'h0, 1, 7, 0, 1), "tmo c7");
    run_vec(mk(0, 0, 0, 0, 32'h0,   0, 0, O_RST,  32'h0, 1, 8, 0, 1), "tmo c8");
    run_vec(mk(1, 0, 0, 0, 32'h0,   0, 0, O_ZERO, 32'h0, 1, 0, 0, 0), "tmo c9");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
